// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache port between the CPU data path and the GP fetch engine.
// Optional GP starvation guard enabled by defining DCARB_STARVE_GUARD_EN.
module dcache_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int LOCK_MAX    = 16,
  parameter int GP_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_we,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          gp_req,
  input  logic          gp_lock,
  input  logic [AW-1:0] gp_addr,
  output logic          gp_ack,
  output logic          gp_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] dcache_addr,
  output logic [3:0]    dcache_we,
  output logic          dcache_re,
  output logic [DW-1:0] dcache_din,
  input  logic [DW-1:0] dcache_dout,
  input  logic          dcache_stall,
  output logic          dbg_state
);

  // Handshake: a request is accepted in the cycle its ack is high; requesters hold
  // their fields until then. rvalid marks rdata for exactly one un-stalled cycle.

  typedef enum logic {ARB = 1'b0, GP_BURST = 1'b1} state_t;

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          rd_pend;
  logic          rd_owner;
  logic          gp_first;
  logic          cpu_win;
  logic          gp_win;
  logic          rd_accept;

`ifdef DCARB_STARVE_GUARD_EN
  localparam int WW = $clog2(GP_MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (gp_win) begin
      wait_cnt <= '0;
    end else if (gp_req && (wait_cnt != WW'(GP_MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign gp_first = gp_req && (wait_cnt == WW'(GP_MAX_WAIT));
`else
  // Without the guard the CPU always beats the GP in ARB.
  assign gp_first = (GP_MAX_WAIT < 0);
`endif

  always_comb begin
    cpu_win = 1'b0;
    gp_win  = 1'b0;
    if (rst && !dcache_stall) begin
      if (state == GP_BURST) begin
        gp_win = gp_req;
      end else if (cpu_req && !gp_first) begin
        cpu_win = 1'b1;
      end else begin
        gp_win = gp_req;
      end
    end
  end

  always_comb begin
    dcache_addr = '0;
    dcache_we   = 4'b0000;
    dcache_re   = 1'b0;
    dcache_din  = '0;
    if (cpu_win) begin
      dcache_addr = cpu_addr;
      dcache_we   = cpu_we;
      dcache_re   = (cpu_we == 4'b0000);
      dcache_din  = cpu_din;
    end else if (gp_win) begin
      dcache_addr = gp_addr;
      dcache_re   = 1'b1;
    end
  end

  assign rd_accept  = (cpu_win && (cpu_we == 4'b0000)) || gp_win;
  assign cpu_ack    = cpu_win;
  assign gp_ack     = gp_win;
  assign cpu_stall  = rst && cpu_req && !cpu_win;
  assign cpu_rvalid = rst && rd_pend && !rd_owner && !dcache_stall;
  assign gp_rvalid  = rst && rd_pend && rd_owner && !dcache_stall;
  assign rdata      = rst ? dcache_dout : '0;
  assign dbg_state  = (state == GP_BURST);

  // A stalled cache freezes everything: pending return, burst progress and state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else if (!dcache_stall) begin
      rd_pend  <= rd_accept;
      rd_owner <= gp_win;
      case (state)
        ARB: begin
          if (gp_win && gp_lock) begin
            state     <= GP_BURST;
            burst_cnt <= CW'(1);
          end
        end
        GP_BURST: begin
          if (!gp_req) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else if (!gp_lock || (burst_cnt == CW'(LOCK_MAX - 1))) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized and directed bench for dcache_port_arbiter against a queue-based reference model.
// Build with DCARB_STARVE_GUARD_EN defined to exercise the GP starvation guard.
module tb_dcache_port_arbiter;

  localparam int LOCK_MAX    = 16;
  localparam int GP_MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [3:0]  cpu_we = '0;
  logic [31:0] cpu_din = '0;
  logic        cpu_ack, cpu_rvalid, cpu_stall;
  logic        gp_req = 1'b0;
  logic        gp_lock = 1'b0;
  logic [31:0] gp_addr = '0;
  logic        gp_ack, gp_rvalid;
  logic [31:0] rdata;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        dcache_stall = 1'b0;
  logic        dbg_state;

  dcache_port_arbiter #(
    .AW(32), .DW(32), .LOCK_MAX(LOCK_MAX), .GP_MAX_WAIT(GP_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .gp_req(gp_req), .gp_lock(gp_lock), .gp_addr(gp_addr),
    .gp_ack(gp_ack), .gp_rvalid(gp_rvalid), .rdata(rdata),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .dcache_stall(dcache_stall),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- cache model (1-cycle read latency, holds on stall) ----------------
  logic [31:0] mem [256];
  bit          mem_init;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (!dcache_stall) begin
      if (dcache_re) dcache_dout <= mem[dcache_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (dcache_we[b]) mem[dcache_addr[9:2]][8*b +: 8] <= dcache_din[8*b +: 8];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [256];
  logic [32:0] exp_q [$];      // {owner_is_gp, data} for reads awaiting return
  int          lock_beats;     // beats taken in the current GP burst, 0 = not bursting
  int          wait_cycles;    // cycles GP has been kept waiting
  bit          e_cpu_ack, e_gp_ack;
  bit          obs_cpu_ack, obs_gp_ack, obs_gp_rvalid, obs_cpu_rvalid, obs_re;
  logic [3:0]  obs_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_beats  = 0;
    wait_cycles = 0;
    exp_q.delete();
    e_cpu_ack = 1'b0;
    e_gp_ack  = 1'b0;
  endtask

  // One clock: check this cycle's outputs at the negedge, advance the model, then move past posedge.
  task automatic step();
    logic [32:0] item;
    logic [31:0] w;
    logic [31:0] ex_addr, ex_din;
    logic [3:0]  ex_we;
    bit          ex_re, gp_first, e_cpu_rv, e_gp_rv;
    @(negedge clk);
    obs_cpu_ack    = cpu_ack;
    obs_gp_ack     = gp_ack;
    obs_gp_rvalid  = gp_rvalid;
    obs_cpu_rvalid = cpu_rvalid;
    obs_re         = dcache_re;
    obs_we         = dcache_we;
    check("dbg_state", 64'(dbg_state), 64'(lock_beats > 0));
    e_cpu_ack = 1'b0;
    e_gp_ack  = 1'b0;
    gp_first  = 1'b0;
`ifdef DCARB_STARVE_GUARD_EN
    gp_first = gp_req && (wait_cycles >= GP_MAX_WAIT);
`endif
    if (!dcache_stall) begin
      if (lock_beats > 0) e_gp_ack = gp_req;
      else if (cpu_req && !gp_first) e_cpu_ack = 1'b1;
      else e_gp_ack = gp_req;
    end
    check("cpu_ack", 64'(cpu_ack), 64'(e_cpu_ack));
    check("gp_ack", 64'(gp_ack), 64'(e_gp_ack));
    check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !e_cpu_ack));
    ex_addr = '0; ex_we = '0; ex_re = 1'b0; ex_din = '0;
    if (e_cpu_ack) begin
      ex_addr = cpu_addr; ex_we = cpu_we; ex_re = (cpu_we == 4'b0); ex_din = cpu_din;
    end else if (e_gp_ack) begin
      ex_addr = gp_addr; ex_re = 1'b1;
    end
    check("dcache_addr", 64'(dcache_addr), 64'(ex_addr));
    check("dcache_we", 64'(dcache_we), 64'(ex_we));
    check("dcache_re", 64'(dcache_re), 64'(ex_re));
    check("dcache_din", 64'(dcache_din), 64'(ex_din));
    e_cpu_rv = 1'b0;
    e_gp_rv  = 1'b0;
    if (!dcache_stall && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      e_gp_rv  = item[32];
      e_cpu_rv = !item[32];
      check("rdata", 64'(rdata), 64'(item[31:0]));
    end
    check("cpu_rvalid", 64'(cpu_rvalid), 64'(e_cpu_rv));
    check("gp_rvalid", 64'(gp_rvalid), 64'(e_gp_rv));
    if (e_cpu_ack) begin
      if (cpu_we == 4'b0) begin
        exp_q.push_back({1'b0, ref_mem[cpu_addr[9:2]]});
      end else begin
        w = ref_mem[cpu_addr[9:2]];
        for (int b = 0; b < 4; b++) if (cpu_we[b]) w[8*b +: 8] = cpu_din[8*b +: 8];
        ref_mem[cpu_addr[9:2]] = w;
      end
    end
    if (e_gp_ack) exp_q.push_back({1'b1, ref_mem[gp_addr[9:2]]});
    if (!dcache_stall) begin
      if (lock_beats > 0) begin
        if (!e_gp_ack) lock_beats = 0;
        else begin
          lock_beats++;
          if (!gp_lock || lock_beats >= LOCK_MAX) lock_beats = 0;
        end
      end else if (e_gp_ack && gp_lock) begin
        lock_beats = 1;
      end
    end
    if (e_gp_ack) wait_cycles = 0;
    else if (gp_req) wait_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
      check("rst_gp_ack", 64'(gp_ack), 64'd0);
      check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
      check("rst_gp_rvalid", 64'(gp_rvalid), 64'd0);
      check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
      check("rst_dcache_re", 64'(dcache_re), 64'd0);
      check("rst_dcache_we", 64'(dcache_we), 64'd0);
      check("rst_dcache_addr", 64'(dcache_addr), 64'd0);
      check("rst_dcache_din", 64'(dcache_din), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_dbg_state", 64'(dbg_state), 64'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  int gp_beats, cpu_at, gp_before, cyc, first_gp, stall_acks;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();

    // Reset held with a CPU read pending; it must be taken in the first cycle after release.
    cpu_req = 1'b1; cpu_addr = 32'h100; cpu_we = 4'b0;
    do_reset(3);
    step();
    check("reset_first_cpu_ack", 64'(obs_cpu_ack), 64'd1);
    cpu_req = 1'b0;
    step();

    // Contention: CPU wins, GP served after CPU drops.
    cpu_req = 1'b1; cpu_addr = 32'h40; cpu_we = 4'b0;
    gp_req = 1'b1; gp_lock = 1'b0; gp_addr = 32'h3000;
    step();
    check("contend_gp_ack", 64'(obs_gp_ack), 64'd0);
    cpu_req = 1'b0;
    step();
    check("contend_cpu_rvalid", 64'(obs_cpu_rvalid), 64'd1);
    check("contend_gp_ack_after", 64'(obs_gp_ack), 64'd1);
    gp_req = 1'b0;
    step();

    // Locked burst of 20 beats, CPU arrives at beat 3 and must wait for forced release.
    gp_req = 1'b1; gp_lock = 1'b1; gp_addr = 32'h2000;
    gp_beats = 0; cpu_at = -1; gp_before = -1; cyc = 0;
    while (gp_beats < 20 && cyc < 100) begin
      if (gp_beats == 3 && cpu_at < 0) begin
        cpu_req = 1'b1; cpu_addr = 32'h500; cpu_we = 4'b0;
      end
      step();
      cyc++;
      if (obs_gp_ack) begin gp_beats++; gp_addr = gp_addr + 32'd4; end
      if (obs_cpu_ack) begin cpu_at = cyc; gp_before = gp_beats; cpu_req = 1'b0; end
    end
    gp_req = 1'b0; gp_lock = 1'b0;
    check("burst_gp_beats_before_cpu", 64'(gp_before), 64'(LOCK_MAX));
    check("burst_cpu_ack_cycle", 64'(cpu_at), 64'(LOCK_MAX + 1));
    check("burst_total_gp_beats", 64'(gp_beats), 64'd20);
    step();
    step();

    // Stall right after a GP read ack: return held, no acks while stalled.
    gp_req = 1'b1; gp_addr = 32'h2400;
    step();
    gp_req = 1'b0; dcache_stall = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h600; cpu_we = 4'b0;
    stall_acks = 0;
    repeat (3) begin
      step();
      stall_acks += int'(obs_cpu_ack) + int'(obs_gp_ack) + int'(obs_gp_rvalid);
    end
    check("stall_no_activity", 64'(stall_acks), 64'd0);
    dcache_stall = 1'b0;
    step();
    check("stall_gp_rvalid_release", 64'(obs_gp_rvalid), 64'd1);
    cpu_req = 1'b0;
    step();

    // Partial CPU write, then read it back.
    cpu_req = 1'b1; cpu_addr = 32'h80; cpu_we = 4'b0011; cpu_din = 32'hDEADBEEF;
    step();
    check("write_dcache_we", 64'(obs_we), 64'h3);
    check("write_dcache_re", 64'(obs_re), 64'd0);
    cpu_we = 4'b0;
    step();
    check("write_no_rvalid", 64'(obs_cpu_rvalid), 64'd0);
    cpu_req = 1'b0;
    step();
    step();

    // Reset with a burst active and a read pending.
    gp_req = 1'b1; gp_lock = 1'b1; gp_addr = 32'h2800;
    step();
    gp_req = 1'b0; gp_lock = 1'b0;
    do_reset(1);
    step();
    step();

    // Starvation: CPU requests every cycle.
    do_reset(1);
    cpu_req = 1'b1; cpu_we = 4'b0; cpu_addr = 32'h0;
    gp_req = 1'b1; gp_lock = 1'b0; gp_addr = 32'h3100;
    first_gp = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (obs_gp_ack && first_gp < 0) first_gp = i;
      if (obs_gp_ack) gp_req = 1'b0;
      if (obs_cpu_ack) cpu_addr = cpu_addr + 32'd4;
    end
`ifdef DCARB_STARVE_GUARD_EN
    check("starve_gp_within_limit", 64'(first_gp >= 1 && first_gp <= GP_MAX_WAIT + 1), 64'd1);
`else
    check("starve_gp_never", 64'(first_gp), 64'(-1));
`endif
    cpu_req = 1'b0; gp_req = 1'b0;
    step();
    step();

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset(2);
      end
      if (!cpu_req || e_cpu_ack) begin
        cpu_req  = ($urandom_range(0, 99) < 55);
        cpu_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        cpu_we   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        cpu_din  = $urandom;
      end else if (dcache_stall && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b0;
      end
      if (!gp_req || e_gp_ack) begin
        gp_req  = ($urandom_range(0, 99) < 60);
        gp_lock = ($urandom_range(0, 99) < 70);
        gp_addr = gp_addr + 32'd4;
      end
      dcache_stall = ($urandom_range(0, 99) < 15);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
